// File: rtl/stimulus_seq_gen.sv
// stimulus_seq_gen: sequenced test-vector driver for characterising basic cells.
// Walks a WIDTH-bit stimulus bus through one of four pattern sets. Each vector
// is held for DWELL clock cycles. A start/busy/done handshake controls the run,
// hold pauses it and abort cancels it. Every output comes from a register.

module stimulus_seq_gen #(
   parameter int WIDTH = 4,
   parameter int DWELL = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             hold,
   input  logic             abort,
   output logic [WIDTH-1:0] stim,
   output logic             stim_valid,
   output logic [WIDTH-1:0] vec_idx,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(DWELL + 1);

   localparam logic [CW-1:0]    CNT_LAST       = CW'(DWELL - 1);
   localparam logic [WIDTH-1:0] IDX_ALL_ONES   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] IDX_WALK_LAST  = WIDTH'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state, state_next;
   logic [1:0]       mode_q, mode_next;
   logic [CW-1:0]    cnt_q, cnt_next;
   logic [WIDTH-1:0] idx_q, idx_next;
   logic [WIDTH-1:0] stim_q, stim_next;
   logic             done_q, done_next;
   logic             last_vec;

   // Pattern for index i under mode m. The walking-one mode only ever sees
   // i < WIDTH, so the shift never runs off the top of the bus.
   function automatic logic [WIDTH-1:0] pattern(input logic [1:0] m,
                                                input logic [WIDTH-1:0] i);
      logic [WIDTH-1:0] p;
      case (m)
         2'd0:    p = i;
         2'd1:    p = i ^ (i >> 1);
         2'd2:    p = WIDTH'(1) << i;
         default: p = ~i;
      endcase
      return p;
   endfunction

   // State and datapath registers. Reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         mode_q <= 2'd0;
         cnt_q  <= '0;
         idx_q  <= '0;
         stim_q <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_next;
         mode_q <= mode_next;
         cnt_q  <= cnt_next;
         idx_q  <= idx_next;
         stim_q <= stim_next;
         done_q <= done_next;
      end
   end

   // Next-state logic. In RUN, abort beats hold. The stimulus for the next
   // index is computed here so that stim stays a plain register output.
   always_comb begin
      state_next = state;
      mode_next  = mode_q;
      cnt_next   = cnt_q;
      idx_next   = idx_q;
      stim_next  = stim_q;
      done_next  = 1'b0;
      last_vec   = (mode_q == 2'd2) ? (idx_q == IDX_WALK_LAST)
                                    : (idx_q == IDX_ALL_ONES);
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
               mode_next  = mode;
               cnt_next   = '0;
               idx_next   = '0;
               stim_next  = pattern(mode, '0);
            end
         end
         RUN: begin
            if (abort) begin
               state_next = IDLE;
               cnt_next   = '0;
               idx_next   = '0;
               stim_next  = '0;
            end else if (!hold) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_next = '0;
                  if (last_vec) begin
                     state_next = IDLE;
                     idx_next   = '0;
                     stim_next  = '0;
                     done_next  = 1'b1;
                  end else begin
                     idx_next  = idx_q + 1'b1;
                     stim_next = pattern(mode_q, idx_q + 1'b1);
                  end
               end else begin
                  cnt_next = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output mapping. Every output comes straight from a register.
   always_comb begin
      busy       = (state == RUN);
      stim_valid = (state == RUN);
      stim       = stim_q;
      vec_idx    = idx_q;
      done       = done_q;
   end

endmodule

// File: tb/tb_stimulus_seq_gen.sv
// tb_stimulus_seq_gen: directed bench for stimulus_seq_gen. Three instances
// cover WIDTH=4/DWELL=20, WIDTH=3/DWELL=2 and WIDTH=4/DWELL=3.

module tb_stimulus_seq_gen;

   logic clk = 1'b0;

   // Clock generator, 10 ns period.
   always #5 clk = ~clk;

   // Instance A: WIDTH=4, DWELL=20
   logic       rstA = 1'b1, startA = 1'b0, holdA = 1'b0, abortA = 1'b0;
   logic [1:0] modeA = 2'd0;
   logic [3:0] stimA, idxA;
   logic       validA, busyA, doneA;

   // Instance B: WIDTH=3, DWELL=2
   logic       rstB = 1'b1, startB = 1'b0, holdB = 1'b0, abortB = 1'b0;
   logic [1:0] modeB = 2'd0;
   logic [2:0] stimB, idxB;
   logic       validB, busyB, doneB;

   // Instance C: WIDTH=4, DWELL=3
   logic       rstC = 1'b1, startC = 1'b0, holdC = 1'b0, abortC = 1'b0;
   logic [1:0] modeC = 2'd0;
   logic [3:0] stimC, idxC;
   logic       validC, busyC, doneC;

   stimulus_seq_gen #(.WIDTH(4), .DWELL(20)) dutA (
      .clk(clk), .rst(rstA), .start(startA), .mode(modeA), .hold(holdA),
      .abort(abortA), .stim(stimA), .stim_valid(validA), .vec_idx(idxA),
      .busy(busyA), .done(doneA)
   );

   stimulus_seq_gen #(.WIDTH(3), .DWELL(2)) dutB (
      .clk(clk), .rst(rstB), .start(startB), .mode(modeB), .hold(holdB),
      .abort(abortB), .stim(stimB), .stim_valid(validB), .vec_idx(idxB),
      .busy(busyB), .done(doneB)
   );

   stimulus_seq_gen #(.WIDTH(4), .DWELL(3)) dutC (
      .clk(clk), .rst(rstC), .start(startC), .mode(modeC), .hold(holdC),
      .abort(abortC), .stim(stimC), .stim_valid(validC), .vec_idx(idxC),
      .busy(busyC), .done(doneC)
   );

   int compared   = 0;
   int mismatched = 0;
   int busyCyc    = 0;

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance one clock edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse start on instance A for one edge with the given mode.
   task automatic applyStimulus(input logic [1:0] m);
      startA = 1'b1;
      modeA  = m;
      step();
      startA = 1'b0;
   endtask

   // Check instance A shows binary vector v for the given number of cycles.
   task automatic checkVecA(input int v, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         checkOutput("A stim", stimA, v);
         checkOutput("A idx", idxA, v);
         checkOutput("A busy", busyA, 1);
         checkOutput("A valid", validA, 1);
         if (busyA) busyCyc++;
         step();
      end
   endtask

   // Check instance A is in its idle/reset output state.
   task automatic checkIdleA(input string tag);
      checkOutput({tag, " busy"}, busyA, 0);
      checkOutput({tag, " valid"}, validA, 0);
      checkOutput({tag, " stim"}, stimA, 0);
      checkOutput({tag, " idx"}, idxA, 0);
      checkOutput({tag, " done"}, doneA, 0);
   endtask

   // Watchdog in case the run never reaches its end.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   int grayTab [8]  = '{0, 1, 3, 2, 6, 7, 5, 4};
   int walkTab [4]  = '{1, 2, 4, 8};
   logic [2:0] prevB;

   initial begin
      // Reset state of all instances
      step();
      step();
      checkIdleA("rst A");
      checkOutput("rst B busy", busyB, 0);
      checkOutput("rst C stim", stimC, 0);
      rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
      step();
      checkIdleA("post-rst A");

      // Binary mode, full run of 16 vectors at 20 cycles each
      applyStimulus(2'd0);
      for (int v = 0; v < 16; v++) checkVecA(v, 20);
      checkOutput("T1 done", doneA, 1);
      checkOutput("T1 busy", busyA, 0);
      checkOutput("T1 stim", stimA, 0);
      step();
      checkOutput("T1 done width", doneA, 0);

      // Gray mode on the 3-bit instance
      startB = 1'b1; modeB = 2'd1;
      step();
      startB = 1'b0;
      prevB = 3'd0;
      for (int v = 0; v < 8; v++) begin
         for (int c = 0; c < 2; c++) begin
            checkOutput("B stim", stimB, grayTab[v]);
            checkOutput("B idx", idxB, v);
            checkOutput("B busy", busyB, 1);
            if (c == 0 && v > 0) checkOutput("B onebit", $countones(stimB ^ prevB), 1);
            if (c == 0) prevB = stimB;
            step();
         end
      end
      checkOutput("B done", doneB, 1);
      checkOutput("B stim end", stimB, 0);

      // Walking-one then descending on the DWELL=3 instance
      startC = 1'b1; modeC = 2'd2;
      step();
      startC = 1'b0;
      for (int v = 0; v < 4; v++) begin
         for (int c = 0; c < 3; c++) begin
            checkOutput("C walk stim", stimC, walkTab[v]);
            checkOutput("C walk idx", idxC, v);
            step();
         end
      end
      checkOutput("C walk done", doneC, 1);
      checkOutput("C walk busy", busyC, 0);
      step();
      startC = 1'b1; modeC = 2'd3;
      step();
      startC = 1'b0;
      for (int v = 0; v < 16; v++) begin
         for (int c = 0; c < 3; c++) begin
            checkOutput("C desc stim", stimC, 15 - v);
            step();
         end
      end
      checkOutput("C desc done", doneC, 1);

      // Hold during vector 3, restart and mode change mid-run are ignored
      busyCyc = 0;
      applyStimulus(2'd0);
      for (int v = 0; v < 16; v++) begin
         if (v == 3) begin
            checkVecA(3, 10);
            holdA = 1'b1;
            checkVecA(3, 5);
            holdA = 1'b0;
            checkVecA(3, 10);
         end else if (v == 5) begin
            startA = 1'b1; modeA = 2'd3;
            checkVecA(5, 1);
            startA = 1'b0;
            checkVecA(5, 19);
         end else if (v == 8) begin
            modeA = 2'd1;
            checkVecA(8, 20);
         end else begin
            checkVecA(v, 20);
         end
      end
      checkOutput("T4 done", doneA, 1);
      checkOutput("T4 busy total", busyCyc, 325);
      step();

      // Abort during vector 7, then a clean full run
      applyStimulus(2'd0);
      for (int v = 0; v < 7; v++) checkVecA(v, 20);
      checkVecA(7, 5);
      abortA = 1'b1;
      step();
      abortA = 1'b0;
      checkIdleA("abort");
      for (int c = 0; c < 3; c++) begin
         step();
         checkOutput("abort no done", doneA, 0);
      end
      applyStimulus(2'd0);
      for (int v = 0; v < 16; v++) checkVecA(v, 20);
      checkOutput("T5 done", doneA, 1);
      step();

      // Reset during vector 5 with start held high
      applyStimulus(2'd0);
      for (int v = 0; v < 5; v++) checkVecA(v, 20);
      checkVecA(5, 3);
      rstA = 1'b1; startA = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         checkIdleA("rst mid");
      end
      rstA = 1'b0; startA = 1'b0;
      step();
      checkIdleA("rst release");

      // Start accepted in the done cycle, new gray run begins with no gap
      applyStimulus(2'd0);
      for (int v = 0; v < 16; v++) checkVecA(v, 20);
      checkOutput("T6 done", doneA, 1);
      startA = 1'b1; modeA = 2'd1;
      step();
      startA = 1'b0;
      checkOutput("T6 busy", busyA, 1);
      checkOutput("T6 stim0", stimA, 0);
      checkOutput("T6 done off", doneA, 0);
      for (int c = 0; c < 20; c++) step();
      checkOutput("T6 stim1", stimA, 1);
      for (int c = 0; c < 20; c++) step();
      checkOutput("T6 stim2", stimA, 3);
      checkOutput("T6 idx2", idxA, 2);
      abortA = 1'b1;
      step();
      abortA = 1'b0;
      checkIdleA("final abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
